// File: rtl/comparator_sweep_driver.sv
// Stimulus/capture driver for a 4-input comparator: sweeps all 16 input vectors,
// holds each for HOLD_CYCLES, samples the result and builds a truth-table word plus ones count.
module comparator_sweep_driver #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        cmp_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [4:0]  ones_count
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("comparator_sweep_driver: HOLD_CYCLES must be in 1..255");
  end
  if ((HOLD_CYCLES - 1) > ((2 ** CNT_W) - 1)) begin : g_bad_cnt_w
    $error("comparator_sweep_driver: CNT_W too narrow for HOLD_CYCLES-1");
  end

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_vec, w_vec_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]      r_result, w_result_nxt;
  logic [4:0]       r_ones, w_ones_nxt;
  logic [3:0]       r_abcd, w_abcd_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_vec_nxt    = r_vec;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_ones_nxt   = r_ones;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_APPLY;
          w_vec_nxt    = 4'd0;
          w_cnt_nxt    = '0;
          w_result_nxt = 16'h0000;
          w_ones_nxt   = 5'd0;
        end
      end
      S_APPLY: begin
        // cmp_out is deliberately not looked at here: the comparator may still be settling
        if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        w_result_nxt[r_vec] = cmp_out;
        w_ones_nxt          = r_ones + {4'd0, cmp_out};
        if (r_vec == 4'd15) begin
          w_state_nxt = S_DONE;
        end else begin
          w_vec_nxt   = r_vec + 4'd1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_APPLY;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they line up with the state they describe
    w_busy_nxt = (w_state_nxt == S_APPLY) || (w_state_nxt == S_SAMPLE);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_abcd_nxt = w_busy_nxt ? w_vec_nxt : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_vec    <= 4'd0;
      r_cnt    <= '0;
      r_result <= 16'h0000;
      r_ones   <= 5'd0;
      r_abcd   <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec    <= w_vec_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_ones   <= w_ones_nxt;
      r_abcd   <= w_abcd_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign {a, b, c, d} = r_abcd;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign ones_count   = r_ones;

endmodule

// File: tb/tb_comparator_sweep_driver.sv
// Scoreboard bench for comparator_sweep_driver: timing model derived from hold/sweep arithmetic,
// expected truth tables queued at start, checked by a monitor on every done pulse.
module tb_comparator_sweep_driver;

  localparam int H0 = 4;
  localparam int H1 = 1;
  localparam int SWEEP0 = 16 * (H0 + 1);
  localparam int L0 = SWEEP0 + 1;
  localparam int P0 = L0 + 1;
  localparam int L1 = 16 * (H1 + 1) + 1;

  logic clk = 1'b0;
  logic rst, start, cmp_out;
  logic a, b, c, d, busy, done;
  logic [15:0] result;
  logic [4:0]  ones_count;

  logic start1, cmp_out1;
  logic a1, b1, c1, d1, busy1, done1;
  logic [15:0] result1;
  logic [4:0]  ones_count1;
  logic [15:0] tt1 = 16'h0000;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [15:0] tbl = 16'h0000;
  bit glitch = 1'b0;
  bit active = 1'b0;
  int base = 0;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  ones;
    int          when_cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  comparator_sweep_driver #(.HOLD_CYCLES(H0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .cmp_out(cmp_out), .busy(busy), .done(done),
    .result(result), .ones_count(ones_count)
  );

  comparator_sweep_driver #(.HOLD_CYCLES(H1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .cmp_out(cmp_out1), .busy(busy1), .done(done1),
    .result(result1), .ones_count(ones_count1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural comparator for the short-hold instance
  assign cmp_out1 = tt1[{a1, b1, c1, d1}];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] gt_table();
    logic [15:0] t;
    t = 16'h0000;
    for (int i = 0; i < 16; i++) t[i] = ((i / 4) > (i % 4));
    return t;
  endfunction

  // Comparator model for the main instance: correct value during the sample cycle of each vector,
  // a toggling value elsewhere when glitch mode is on
  always @(negedge clk) begin
    int k, v;
    bit samp;
    k = (cyc - base) % P0;
    samp = (k >= H0 + 1) && (k <= SWEEP0) && ((k % (H0 + 1)) == 0);
    v = (k >= 1 && k <= SWEEP0) ? (k - 1) / (H0 + 1) : 0;
    if (glitch && !samp) cmp_out = cyc[0];
    else cmp_out = tbl[v];
  end

  // Monitor: per-cycle drive check while a run is tracked, scoreboard pop on each done pulse
  always @(negedge clk) begin
    int k;
    bit eb;
    logic [3:0] ev;
    exp_t e;
    if (active) begin
      k = (cyc - base) % P0;
      eb = (k >= 1) && (k <= SWEEP0);
      ev = eb ? 4'((k - 1) / (H0 + 1)) : 4'd0;
      chk("busy", 32'(busy), 32'(eb));
      chk("abcd", 32'({a, b, c, d}), 32'(ev));
    end
    if (done) begin
      if (q0.size() == 0) chk("spurious_done", 32'(done), 32'd0);
      else begin
        e = q0.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("ones_count", 32'(ones_count), 32'(e.ones));
        chk("done_cycle", 32'(cyc), 32'(e.when_cyc));
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("spurious_done1", 32'(done1), 32'd0);
      else begin
        e = q1.pop_front();
        chk("result1", 32'(result1), 32'(e.res));
        chk("ones_count1", 32'(ones_count1), 32'(e.ones));
        chk("done_cycle1", 32'(cyc), 32'(e.when_cyc));
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // mode 0: plain sweep, 1: start re-pulsed mid-sweep, 2: reset at edge 30
  task automatic sweep(input logic [15:0] tt, input bit gl, input int mode);
    int b0;
    @(negedge clk);
    tbl = tt; glitch = gl; base = cyc; b0 = cyc; active = 1'b1; start = 1'b1;
    q0.push_back('{tt, 5'($countones(tt)), b0 + L0});
    @(negedge clk);
    start = 1'b0;
    if (mode == 2) begin
      wait_until(b0 + 29);
      rst = 1'b1; active = 1'b0;
      void'(q0.pop_back());
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_abcd", 32'({a, b, c, d}), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_ones", 32'(ones_count), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      rst = 1'b0;
      return;
    end
    if (mode == 1) begin
      wait_until(b0 + 9);  start = 1'b1;
      @(negedge clk);      start = 1'b0;
      wait_until(b0 + 49); start = 1'b1;
      @(negedge clk);      start = 1'b0;
    end
    wait_until(b0 + L0 + 1);
    active = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_result", 32'(result), 32'(tt));
    chk("hold_ones", 32'(ones_count), 32'($countones(tt)));
  endtask

  task automatic held(input logic [15:0] tt, input int n);
    int b0;
    @(negedge clk);
    tbl = tt; glitch = 1'b0; base = cyc; b0 = cyc; active = 1'b1; start = 1'b1;
    for (int r = 0; r < n; r++) q0.push_back('{tt, 5'($countones(tt)), b0 + r * P0 + L0});
    wait_until(b0 + (n - 1) * P0 + L0);
    start = 1'b0;
    wait_until(b0 + (n - 1) * P0 + L0 + 1);
    active = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_busy_after", 32'(busy), 32'd0);
  endtask

  task automatic sweep1(input logic [15:0] tt);
    int b0;
    @(negedge clk);
    tt1 = tt; b0 = cyc; start1 = 1'b1;
    q1.push_back('{tt, 5'($countones(tt)), b0 + L1});
    @(negedge clk);
    start1 = 1'b0;
    wait_until(b0 + L1 + 2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; start1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_abcd", 32'({a, b, c, d}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ones", 32'(ones_count), 32'd0);
    rst = 1'b0; start = 1'b0; start1 = 1'b0;

    sweep(16'hFFFF, 1'b0, 0);
    sweep(gt_table(), 1'b0, 0);
    sweep(16'($urandom), 1'b0, 2);
    sweep(16'($urandom), 1'b0, 0);
    sweep(16'($urandom), 1'b0, 1);
    held(16'($urandom), 3);
    sweep(16'hAAAA, 1'b1, 0);
    sweep(16'h0000, 1'b1, 0);
    for (int i = 0; i < 3; i++) sweep(16'($urandom), 1'($urandom_range(0, 1)), 0);
    sweep1(16'hAAAA);
    sweep1(16'($urandom));

    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_sweep_driver.md
Name: comparator_sweep_driver

Overview:
Upstream stimulus/capture stage for the 4-input comparator (single-bit inputs a, b, c, d; single-bit result out). On start, the block sweeps all 16 input combinations and holds each one for a programmable settle time. It samples the comparator result for each vector and assembles a 16-bit truth-table word plus a ones count. This gives on-chip self-check of the comparator without a host-driven bench.

Parameters:
HOLD_CYCLES, 4, cycles each vector is driven before sampling; legal range 1..255; 0 is an elaboration error.
CNT_W, 8, width of the internal hold counter; must hold HOLD_CYCLES-1.

Ports:
clk  in  1  single system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  level; sampled only in IDLE.
a  out  1  comparator input a; vector index bit 3 (MSB).
b  out  1  comparator input b; vector index bit 2.
c  out  1  comparator input c; vector index bit 1.
d  out  1  comparator input d; vector index bit 0 (LSB).
cmp_out  in  1  comparator result (its out port).
busy  out  1  high in APPLY and SAMPLE.
done  out  1  one-cycle pulse when the sweep completes.
result  out  16  bit i = cmp_out sampled while {a,b,c,d} == i.
ones_count  out  5  number of set bits in result (0..16).

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - FSM enters IDLE; vec=0; hold counter=0.
  - a, b, c, d, busy, done = 0; result = 16'h0000; ones_count = 0.
  - Reset overrides start and any in-progress sweep.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - a..d = 0, busy = 0.
  - start=1 -> APPLY, with vec=0, counter=0, result cleared, ones_count cleared.
- APPLY:
  - {a,b,c,d} = vec (registered outputs).
  - Counter increments each cycle; when counter == HOLD_CYCLES-1 -> SAMPLE.
  - cmp_out is ignored in this state; glitches here are never captured.
- SAMPLE (exactly 1 cycle):
  - a..d still = vec.
  - result[vec] <= cmp_out; ones_count <= ones_count + cmp_out.
  - vec == 15 -> DONE; otherwise vec <= vec+1, counter <= 0, -> APPLY.
- DONE (exactly 1 cycle):
  - done = 1, busy = 0, a..d = 0.
  - Unconditional -> IDLE; start is ignored in this state.
- Timing: done is high after edge number 16*(HOLD_CYCLES+1)+1, counting the edge that samples start as edge 1. With HOLD_CYCLES=4, done is high after edge 81.
- Back-to-back runs: with start held high continuously, done pulses every 16*(HOLD_CYCLES+1)+2 cycles (82 for the default).
- start while busy or in DONE: ignored; the sweep is not restarted or extended.
- result and ones_count hold their values after DONE until the next accepted start or reset.
- No wrap-around: the 4-bit vec never passes 15. ones_count cannot overflow (maximum 16 fits in 5 bits).
- All outputs are registered; no combinational path from cmp_out or start to any output.

Test Plan:
1. Reset: assert rst 2 cycles with start=1 -> a..d=0, busy=0, done=0, result=16'h0000, ones_count=0.
2. cmp_out tied 1, HOLD_CYCLES=4, start pulse -> busy high from edge 1; done pulse after edge 81; result=16'hFFFF; ones_count=16.
3. Behavioural comparator cmp_out = ({a,b} > {c,d}) -> result=16'h7310, ones_count=6. Also check each vector is held 5 cycles in order 0..15.
4. rst asserted for 1 cycle at edge 30 of a sweep -> next edge shows busy=0, a..d=0, result=0, and no done. A new start then completes normally with done after edge 81.
5. start re-pulsed at edges 10 and 50 during a sweep -> ignored; single done at edge 81. start held high -> done pulses at edges 81, 163, 245.
6. cmp_out toggling every cycle during APPLY but driven to (vec odd) during SAMPLE -> result=16'hAAAA, ones_count=8. HOLD_CYCLES=1 build -> done after edge 33.
